// File: rtl/esp32_rx_ram_writer.sv
// Packs received UART bytes little-endian into 32-bit words and writes them to a RAM,
// flushing a partial word after an idle timeout and stopping when the RAM region is full.
module esp32_rx_ram_writer #(
   parameter int unsigned DEPTH_WORDS  = 51200,
   parameter int unsigned IDLE_TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        clear,
   output logic [15:0] address,
   output logic [3:0]  byteenable,
   output logic        chipselect,
   output logic        write,
   output logic [31:0] writedata,
   output logic        clken,
   output logic [15:0] word_count,
   output logic        full
);

   localparam int unsigned IDLE_W = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         lanes_q, lanes_d, lanes_acc;
   logic [2:0]          nbytes_q, nbytes_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic [15:0]         wc_q, wc_d;
   logic                full_q, full_d;
   logic                rdy_q, rdy_d;
   logic                wr_q, wr_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                clken_q;
   logic                accept;

   // Clear drops any byte offered in the same cycle.
   assign rx_ready = rdy_q & ~clear;
   assign accept   = rx_valid & rx_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         lanes_q  <= '0;
         nbytes_q <= '0;
         idle_q   <= '0;
         wc_q     <= '0;
         full_q   <= 1'b0;
         rdy_q    <= 1'b0;
         wr_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         clken_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lanes_q  <= lanes_d;
         nbytes_q <= nbytes_d;
         idle_q   <= idle_d;
         wc_q     <= wc_d;
         full_q   <= full_d;
         rdy_q    <= rdy_d;
         wr_q     <= wr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         clken_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      lanes_d   = lanes_q;
      nbytes_d  = nbytes_q;
      idle_d    = idle_q;
      wc_d      = wc_q;
      full_d    = full_q;
      wr_d      = 1'b0;
      be_d      = '0;
      wdata_d   = '0;
      lanes_acc = lanes_q;
      if (accept) lanes_acc[{nbytes_q[1:0], 3'b000} +: 8] = rx_data;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               lanes_d  = lanes_acc;
               nbytes_d = 3'd1;
               idle_d   = '0;
               state_d  = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // A new byte restarts the idle window; otherwise count toward a flush.
            if (accept) begin
               lanes_d  = lanes_acc;
               nbytes_d = nbytes_q + 3'd1;
               idle_d   = '0;
               if (nbytes_q == 3'd3) state_d = ST_WRITE;
            end else if (32'(idle_q) == IDLE_TIMEOUT) begin
               state_d = ST_WRITE;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         ST_WRITE: begin
            state_d  = ST_IDLE;
            lanes_d  = '0;
            nbytes_d = '0;
            idle_d   = '0;
            wc_d     = wc_q + 16'd1;
            full_d   = full_q | ((32'(wc_q) + 32'd1) == DEPTH_WORDS);
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_WRITE) begin
         wr_d    = 1'b1;
         wdata_d = lanes_d;
         case (nbytes_d)
            3'd1:    be_d = 4'b0001;
            3'd2:    be_d = 4'b0011;
            3'd3:    be_d = 4'b0111;
            default: be_d = 4'b1111;
         endcase
      end

      // A write already on the bus completes; clear lands on the following edge.
      if (clear) begin
         state_d  = ST_IDLE;
         lanes_d  = '0;
         nbytes_d = '0;
         idle_d   = '0;
         wc_d     = '0;
         full_d   = 1'b0;
         wr_d     = 1'b0;
         be_d     = '0;
         wdata_d  = '0;
      end
   end

   always_comb rdy_d = (state_d != ST_WRITE) && !full_d;

   assign address    = wc_q;
   assign word_count = wc_q;
   assign full       = full_q;
   assign write      = wr_q;
   assign chipselect = wr_q;
   assign byteenable = be_q;
   assign writedata  = wdata_q;
   assign clken      = clken_q;

endmodule
